vram_access_arbiter: RTL and testbench

- Controller and arbiter for the single-port synchronous video RAM (VRAM).
- After `start`, it first sequences a one-shot ROM-to-RAM initial copy.
- It then shares the RAM port between two requesters, each granted per cycle:
  - display scanout read port (high priority);
  - draw-engine read/write port.
- Sits between the ROM/RAM primitives, the VGA sync/pixel path and the drawing engine.

---
 rtl/vga_mem_pkg.sv | 17 +
 rtl/vram_init_sequencer.sv | 32 +++
 rtl/vram_access_arbiter.sv | 137 +++++++++++++
 tb/tb_vram_access_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// Shared definitions for the VRAM controller slice: FSM states, requester IDs
// and default bus widths.
package vga_mem_pkg;

  localparam int VGA_ADDR_W = 8;
  localparam int VGA_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;

  localparam logic REQ_DISP = 1'b0;
  localparam logic REQ_DRAW = 1'b1;

endpackage

// File: rtl/vram_init_sequencer.sv
// ROM-to-RAM initial copy sequencer: walks word addresses 0..LOAD_WORDS-1
// while i_load is high and flags the cycle that writes the last word.
module vram_init_sequencer
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W     = VGA_ADDR_W,
  parameter int LOAD_WORDS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done
);

  // One extra bit so a full-depth load reaches its last word without wrapping.
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(LOAD_WORDS - 1);

  logic [ADDR_W:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || !i_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + (ADDR_W+1)'(1);
    end
  end

  assign o_addr = i_load ? r_cnt[ADDR_W-1:0] : '0;
  assign o_done = i_load && (r_cnt == LAST_WORD);

endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port VRAM controller: one-shot ROM copy, then per-cycle arbitration
// between display scanout (priority) and the draw engine.
// Optional anti-starvation draw grant: define VRAM_ARB_STARVE_GUARD_EN.
module vram_access_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W       = VGA_ADDR_W,
  parameter int DATA_W       = VGA_DATA_W,
  parameter int LOAD_WORDS   = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              load_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              draw_req,
  input  logic              draw_we,
  input  logic [ADDR_W-1:0] draw_addr,
  input  logic [DATA_W-1:0] draw_wdata,
  output logic              draw_gnt,
  output logic              draw_rvalid,
  output logic [DATA_W-1:0] draw_rdata
);

  if (LOAD_WORDS < 1 || LOAD_WORDS > (1 << ADDR_W) || STARVE_LIMIT < 1) begin : g_param_check
    $error("vram_access_arbiter: LOAD_WORDS or STARVE_LIMIT out of range");
  end

  state_t            r_state;
  logic              r_rd_vld_p1;
  logic              r_rd_id_p1;
  logic [ADDR_W-1:0] w_seq_addr;
  logic              w_seq_done;
  logic              w_in_load;
  logic              w_in_serve;
  logic              w_force_draw;
  logic              w_disp_gnt;
  logic              w_draw_gnt;

  vram_init_sequencer #(
    .ADDR_W    (ADDR_W),
    .LOAD_WORDS(LOAD_WORDS)
  ) u_init_seq (
    .clk   (clk),
    .reset (reset),
    .i_load(r_state == LOAD),
    .o_addr(w_seq_addr),
    .o_done(w_seq_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) r_state <= LOAD;
        LOAD:    if (w_seq_done) r_state <= SERVE;
        SERVE:   r_state <= SERVE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset also masks the combinational outputs so it wins within its own cycle.
  assign w_in_load  = (r_state == LOAD) && !reset;
  assign w_in_serve = (r_state == SERVE) && !reset;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] r_starve;

  always_ff @(posedge clk) begin
    if (reset || !w_in_serve || !draw_req || w_draw_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_MAX) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  assign w_force_draw = draw_req && (r_starve == STARVE_MAX);
`else
  assign w_force_draw = 1'b0;
`endif

  assign w_disp_gnt = w_in_serve && disp_req && !w_force_draw;
  assign w_draw_gnt = w_in_serve && draw_req && (!disp_req || w_force_draw);

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_in_load) begin
      ram_we    = 1'b1;
      ram_addr  = w_seq_addr;
      ram_wdata = rom_data;
    end else if (w_disp_gnt) begin
      ram_addr  = disp_addr;
    end else if (w_draw_gnt) begin
      ram_we    = draw_we;
      ram_addr  = draw_addr;
      ram_wdata = draw_wdata;
    end
  end

  // ---- p0 -> p1: tag the granted read so its data returns to the right port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_disp_gnt || (w_draw_gnt && !draw_we);
    end
    r_rd_id_p1 <= w_disp_gnt ? REQ_DISP : REQ_DRAW;
  end

  assign load_done   = w_in_serve;
  assign rom_addr    = w_in_load ? w_seq_addr : '0;
  assign disp_gnt    = w_disp_gnt;
  assign draw_gnt    = w_draw_gnt;
  assign disp_rvalid = r_rd_vld_p1 && (r_rd_id_p1 == REQ_DISP) && !reset;
  assign draw_rvalid = r_rd_vld_p1 && (r_rd_id_p1 == REQ_DRAW) && !reset;
  assign disp_rdata  = ram_rdata;
  assign draw_rdata  = ram_rdata;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Randomized bench for vram_access_arbiter with a cycle-level reference model,
// a behavioural ROM (word i = 0xA0+i) and a single-port RAM with 1-cycle read.
module tb_vram_access_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int WORDS = 7;
  localparam int LIMIT = 4;
`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic          load_done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          draw_req, draw_we;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_wdata;
  logic          draw_gnt, draw_rvalid;
  logic [DW-1:0] draw_rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] ram_arr [256];
  logic [DW-1:0] ref_mem [256];

  // Reference model state
  int            m_phase;   // 0 idle, 1 loading, 2 serving
  int            m_words;   // words copied so far
  int            m_starve;  // consecutive lost draw cycles
  int            m_pend;    // -1 none, 0 display read, 1 draw read
  logic [DW-1:0] m_pend_data;
  bit            m_gd, m_gw;

  always #5 clk = ~clk;

  assign rom_data = 32'hA0 + DW'(rom_addr);

  always @(posedge clk) begin
    if (ram_we) ram_arr[ram_addr] <= ram_wdata;
    ram_rdata <= ram_arr[ram_addr];
  end

  vram_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LOAD_WORDS(WORDS), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_done(load_done),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_gnt(draw_gnt), .draw_rvalid(draw_rvalid), .draw_rdata(draw_rdata)
  );

  task automatic chk_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare all outputs against the model, advance the model.
  task automatic step(input logic rst, input logic st,
                      input logic dq, input logic [AW-1:0] da,
                      input logic wq, input logic ww, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    logic          e_ld, e_dg, e_wg, e_we, e_dv, e_wv;
    logic [AW-1:0] e_addr, e_rom;
    logic [DW-1:0] e_wdata, e_rd, nxt_data;
    bit            do_wdata, do_rom, force_draw;
    int            nxt_pend;
    @(negedge clk);
    reset = rst; start = st;
    disp_req = dq; disp_addr = da;
    draw_req = wq; draw_we = ww; draw_addr = wa; draw_wdata = wd;
    #1;
    e_ld = 0; e_dg = 0; e_wg = 0; e_we = 0; e_dv = 0; e_wv = 0;
    e_addr = '0; e_rom = '0; e_wdata = '0; e_rd = m_pend_data;
    do_wdata = 1; do_rom = 1; nxt_pend = -1; nxt_data = '0;
    if (rst) begin
      m_phase = 0; m_words = 0; m_starve = 0;
    end else begin
      e_dv = (m_pend == 0);
      e_wv = (m_pend == 1);
      case (m_phase)
        0: if (st) begin m_phase = 1; m_words = 0; end
        1: begin
          e_we = 1; e_addr = AW'(m_words); e_rom = AW'(m_words);
          e_wdata = 32'hA0 + DW'(m_words);
          ref_mem[m_words] = e_wdata;
          m_words++;
          if (m_words == WORDS) m_phase = 2;
        end
        default: begin
          e_ld = 1; do_rom = 0;
          force_draw = GUARD && wq && (m_starve >= LIMIT);
          if (dq && !force_draw) begin
            e_dg = 1; e_addr = da; do_wdata = 0;
            nxt_pend = 0; nxt_data = ref_mem[da];
          end else if (wq) begin
            e_wg = 1; e_addr = wa; e_we = ww; e_wdata = wd;
            if (ww) ref_mem[wa] = wd;
            else begin nxt_pend = 1; nxt_data = ref_mem[wa]; end
          end
          if (wq && !e_wg) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
          else m_starve = 0;
        end
      endcase
    end
    m_pend = nxt_pend; m_pend_data = nxt_data;
    m_gd = e_dg; m_gw = e_wg;
    chk_eq("load_done", load_done, e_ld);
    chk_eq("disp_gnt", disp_gnt, e_dg);
    chk_eq("draw_gnt", draw_gnt, e_wg);
    chk_eq("ram_we", ram_we, e_we);
    chk_eq("ram_addr", ram_addr, e_addr);
    if (do_wdata) chk_eq("ram_wdata", ram_wdata, e_wdata);
    if (do_rom) chk_eq("rom_addr", rom_addr, e_rom);
    chk_eq("disp_rvalid", disp_rvalid, e_dv);
    chk_eq("draw_rvalid", draw_rvalid, e_wv);
    if (e_dv) chk_eq("disp_rdata", disp_rdata, e_rd);
    if (e_wv) chk_eq("draw_rdata", draw_rdata, e_rd);
  endtask

  task automatic noise(input logic rst, input logic st);
    step(rst, st, 1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
         AW'($urandom), $urandom);
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    logic          dq, wq, ww;
    logic [AW-1:0] da, wa;
    logic [DW-1:0] wd;
    int            draw_wins, first_win;

    for (int i = 0; i < 256; i++) begin ram_arr[i] = '0; ref_mem[i] = '0; end
    ram_rdata = '0;
    m_phase = 0; m_words = 0; m_starve = 0; m_pend = -1; m_pend_data = '0;
    reset = 1; start = 0; disp_req = 0; disp_addr = '0;
    draw_req = 0; draw_we = 0; draw_addr = '0; draw_wdata = '0;

    // Reset, idle with stray requests, start, load with stray requests
    noise(1, 0); noise(1, 0);
    noise(0, 0); noise(0, 0);
    noise(0, 1);
    for (int i = 0; i < WORDS; i++) noise(0, 0);
    idle_cycle();
    chk_eq("load_done_after_8", load_done, 1'b1);

    // Display read of the loaded word 3
    step(0, 0, 1, 8'd3, 0, 0, '0, '0);
    idle_cycle();
    chk_eq("disp_rd3_valid", disp_rvalid, 1'b1);
    chk_eq("disp_rd3_data", disp_rdata, 32'hA3);

    // Draw write then read back
    step(0, 0, 0, '0, 1, 1, 8'd5, 32'h55);
    step(0, 0, 0, '0, 1, 0, 8'd5, '0);
    idle_cycle();
    chk_eq("draw_rd5_valid", draw_rvalid, 1'b1);
    chk_eq("draw_rd5_data", draw_rdata, 32'h55);

    // Both requesters held high for 10 cycles
    draw_wins = 0; first_win = 0;
    for (int c = 1; c <= 10; c++) begin
      step(0, 0, 1, 8'd1, 1, 0, 8'd2, '0);
      if (m_gw) begin
        draw_wins++;
        if (first_win == 0) first_win = c;
      end
      chk_eq("contend_draw_gnt_obs", draw_gnt, m_gw);
    end
    chk_eq("contend_draw_wins", draw_wins, GUARD ? 2 : 0);
    chk_eq("contend_first_win", first_win, GUARD ? 5 : 0);
    idle_cycle();

    // Randomized traffic: each requester holds its request until granted
    dq = 0; da = '0; wq = 0; ww = 0; wa = '0; wd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!dq || m_gd) begin dq = ($urandom_range(0, 2) == 0); da = AW'($urandom_range(0, 15)); end
      if (!wq || m_gw) begin
        wq = ($urandom_range(0, 1) == 0); ww = 1'($urandom);
        wa = AW'($urandom_range(0, 15)); wd = $urandom;
      end
      step(0, 0, dq, da, wq, ww, wa, wd);
    end
    idle_cycle(); idle_cycle();

    // Reset in the middle of a load, then a full reload from word 0
    noise(1, 0); noise(1, 0);
    noise(0, 1);
    noise(0, 0); noise(0, 0); noise(0, 0);
    noise(1, 1);
    chk_eq("reset_mid_load_done", load_done, 1'b0);
    noise(0, 0);
    noise(0, 1);
    chk_eq("reload_first_addr", ram_addr, 8'd0);
    for (int i = 0; i < WORDS; i++) noise(0, 0);
    for (int i = 0; i < 20; i++) noise(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
